// File: rtl/wb_loopback_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_loopback_fifo
// Brief    : Wishbone slave with a 32-bit loopback FIFO, status/threshold
//            registers and a level interrupt. Optional macro
//            LOOPBACK_FIFO_PEEK_EN maps a non-popping head read at address 4.
// Revision : 1.0 - initial release
// ============================================================================
module wb_loopback_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wbs_we,
    input  logic [3:0]  i_wbs_sel,
    input  logic        i_wbs_cyc,
    input  logic        i_wbs_stb,
    input  logic [31:0] i_wbs_adr,
    input  logic [31:0] i_wbs_dat,
    output logic [31:0] o_wbs_dat,
    output logic        o_wbs_ack,
    output logic        o_wbs_int
);

    localparam int                  c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [2:0] c_ADR_CONTROL = 3'd0;
    localparam logic [2:0] c_ADR_STATUS  = 3'd1;
    localparam logic [2:0] c_ADR_DATA    = 3'd2;
    localparam logic [2:0] c_ADR_THRESH  = 3'd3;
`ifdef LOOPBACK_FIFO_PEEK_EN
    localparam logic [2:0] c_ADR_PEEK    = 3'd4;
`endif

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    logic [31:0]           r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   r_thresh;
    logic                  r_int_en;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  r_ack;
    logic                  r_armed;
    logic [31:0]           r_dat;
    logic                  r_int;
    logic [2:0]            w_adr;
    logic                  w_start;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [31:0]           w_head;
    logic [31:0]           w_rd_data;
    logic                  w_unused_bits;

    // Reset asserts immediately but is released only after two clean clock edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_adr         = i_wbs_adr[2:0];
    assign w_unused_bits = ^{i_wbs_sel, i_wbs_adr[31:3]};
    // r_armed blocks a strobe that was already high across a reset
    assign w_start       = i_wbs_cyc & i_wbs_stb & ~r_ack & r_armed;
    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == c_FULL_COUNT);
    assign w_push        = w_start & i_wbs_we & (w_adr == c_ADR_DATA);
    assign w_pop         = w_start & ~i_wbs_we & (w_adr == c_ADR_DATA);
    assign w_head        = r_mem[r_rd_ptr];

    always_comb begin
        w_rd_data = '0;
        case (w_adr)
            c_ADR_CONTROL: w_rd_data[0] = r_int_en;
            c_ADR_STATUS: begin
                w_rd_data[DEPTH_LOG2:0] = r_count;
                w_rd_data[16]           = w_empty;
                w_rd_data[17]           = w_full;
                w_rd_data[18]           = r_ovf;
                w_rd_data[19]           = r_udf;
            end
            c_ADR_DATA: begin
                if (!w_empty) w_rd_data = w_head;
            end
            c_ADR_THRESH: w_rd_data[DEPTH_LOG2:0] = r_thresh;
`ifdef LOOPBACK_FIFO_PEEK_EN
            c_ADR_PEEK: begin
                if (!w_empty) w_rd_data = w_head;
            end
`endif
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push && !w_full) begin
            r_mem[r_wr_ptr] <= i_wbs_dat;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_thresh <= {{DEPTH_LOG2{1'b0}}, 1'b1};
            r_int_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_ack    <= 1'b0;
            r_armed  <= 1'b0;
            r_dat    <= '0;
            r_int    <= 1'b0;
        end else begin
            if (!i_wbs_stb) begin
                r_armed <= 1'b1;
            end

            if (w_start) begin
                r_armed <= 1'b0;
                r_ack   <= 1'b1;
                r_dat   <= i_wbs_we ? 32'h0 : w_rd_data;
            end else if (!i_wbs_stb) begin
                r_ack   <= 1'b0;
            end

            if (w_start && i_wbs_we) begin
                case (w_adr)
                    c_ADR_CONTROL: begin
                        r_int_en <= i_wbs_dat[0];
                        if (i_wbs_dat[1]) begin
                            r_wr_ptr <= '0;
                            r_rd_ptr <= '0;
                            r_count  <= '0;
                        end
                        if (i_wbs_dat[2]) begin
                            r_ovf <= 1'b0;
                            r_udf <= 1'b0;
                        end
                    end
                    c_ADR_THRESH: r_thresh <= i_wbs_dat[DEPTH_LOG2:0];
                    c_ADR_DATA: begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            r_count  <= r_count + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (w_pop) begin
                if (w_empty) begin
                    r_udf <= 1'b1;
                end else begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_count  <= r_count - 1'b1;
                end
            end

            r_int <= r_int_en && ((r_count >= r_thresh) || r_ovf);
        end
    end

    assign o_wbs_ack = r_ack;
    assign o_wbs_dat = r_dat;
    assign o_wbs_int = r_int;

endmodule
`default_nettype wire
